// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared types and AHB constants for the DMAC bus arbiter
// Contents:
//   arb_state_e        arbiter state encoding (IDLE, OWNED, HANDOVER)
//   HTRANS_* constants AHB HTRANS encodings
package dmac_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_OWNED    = 2'd1,
      ARB_HANDOVER = 2'd2
   } arb_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner picker
// Ports:
//   req    [N-1:0]      request vector
//   start  [IDX_W-1:0]  index with highest priority; scan wraps upward from here
//   grant  [N-1:0]      one-hot winner (zero when no request)
//   valid               any request present
module rr_picker #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     grant,
   output logic             valid
);

   always_comb begin
      int  idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(start) + i;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/dmac_bus_arbiter.sv
// rtl/dmac_bus_arbiter.sv - AHB-lite bus arbiter sharing one master port among requesters
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   Bus_Req       per-master level request
//   HReady        HREADY from the selected slave
//   HTrans        HTRANS of the currently muxed master
//   Bus_Grant     registered one-hot grant
//   Grant_Idx     encoded owner index (bus mux select)
//   Bus_Owned     any grant active
//   Hold_Expired  one-cycle pulse on a forced (hold-limit) release
module dmac_bus_arbiter
   import dmac_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int RR_EN       = 1,
   parameter int MAX_HOLD    = 64,
   localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int HC_W       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] Bus_Req,
   input  logic                   HReady,
   input  logic [1:0]             HTrans,
   output logic [NUM_MASTERS-1:0] Bus_Grant,
   output logic [IDX_W-1:0]       Grant_Idx,
   output logic                   Bus_Owned,
   output logic                   Hold_Expired
);

   localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD);

   arb_state_e             state;
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       start_ptr;
   logic [IDX_W-1:0]       win_idx;
   logic [IDX_W-1:0]       next_ptr;
   logic [HC_W-1:0]        hold_cnt;
   logic [NUM_MASTERS-1:0] win_oh;
   logic                   win_valid;
   logic                   owner_req;
   logic                   others_req;
   logic                   safe_beat;
   logic                   hold_hit;

   // Fixed priority is round-robin with the scan always starting at index 0.
   assign start_ptr = (RR_EN != 0) ? rr_ptr : '0;

   rr_picker #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req   (Bus_Req),
      .start (start_ptr),
      .grant (win_oh),
      .valid (win_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (win_oh[i]) win_idx = IDX_W'(i);
      end
   end

   assign owner_req  = |(Bus_Req & Bus_Grant);
   assign others_req = |(Bus_Req & ~Bus_Grant);
   // Never break a burst: only a completed non-SEQ/non-BUSY beat is a safe boundary.
   assign safe_beat  = HReady && (HTrans != HTRANS_SEQ) && (HTrans != HTRANS_BUSY);
   // hold_cnt saturates at the limit, so equality is the ">= limit" test.
   assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && others_req;
   assign next_ptr   = (Grant_Idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : Grant_Idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ARB_IDLE;
         rr_ptr       <= '0;
         hold_cnt     <= '0;
         Bus_Grant    <= '0;
         Grant_Idx    <= '0;
         Bus_Owned    <= 1'b0;
         Hold_Expired <= 1'b0;
      end else begin
         Hold_Expired <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (win_valid && HReady) begin
                  Bus_Grant <= win_oh;
                  Grant_Idx <= win_idx;
                  Bus_Owned <= 1'b1;
                  hold_cnt  <= '0;
                  state     <= ARB_OWNED;
               end
            end
            ARB_OWNED: begin
               if (hold_cnt != HOLD_LIM) hold_cnt <= hold_cnt + 1'b1;
               if (safe_beat && (!owner_req || hold_hit)) begin
                  Bus_Grant    <= '0;
                  Bus_Owned    <= 1'b0;
                  // Owner still requesting means this release was forced by the limit.
                  Hold_Expired <= owner_req;
                  state        <= ARB_HANDOVER;
               end
            end
            ARB_HANDOVER: begin
               // Grant_Idx is kept through the dead cycle so the last data phase stays muxed.
               if (RR_EN != 0) rr_ptr <= next_ptr;
               state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
